// File: rtl/mem_2r1w_sync_pkg.sv
// Shared definitions for the 2-read / 1-write synchronous register file.
package mem_2r1w_sync_pkg;

  localparam int unsigned default_width_lp = 32;
  localparam int unsigned default_els_lp   = 32;

  // Address width that never collapses to zero bits, even for a one-word array.
  function automatic int safe_clog2(input int n);
    if (n <= 32'sd2) begin
      return 32'sd1;
    end else begin
      return $clog2(n);
    end
  endfunction

  // True when an address selects a physically present word.
  function automatic logic addr_in_range(input int unsigned addr, input int unsigned els);
    return (addr < els);
  endfunction

endpackage

// File: rtl/mem_2r1w_sync_checker.sv
// Simulation-side monitor flagging same-cycle read/write collisions on one address.
module mem_2r1w_sync_checker #(
  parameter int addr_width_p = 5,
  parameter int harden_p     = 0
) (
  input logic                    clk_i,
  input logic                    reset_n_i,
  input logic                    w_v_i,
  input logic [addr_width_p-1:0] w_addr_i,
  input logic                    r0_v_i,
  input logic [addr_width_p-1:0] r0_addr_i,
  input logic                    r1_v_i,
  input logic [addr_width_p-1:0] r1_addr_i
);

  // Report any read that targets the word being written in the same cycle.
  always @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(w_v_i && r0_v_i && (w_addr_i == r0_addr_i)))
        else $error("mem_2r1w_sync(harden=%0d): read port 0 collides with write at address %0d",
                    harden_p, r0_addr_i);
      assert (!(w_v_i && r1_v_i && (w_addr_i == r1_addr_i)))
        else $error("mem_2r1w_sync(harden=%0d): read port 1 collides with write at address %0d",
                    harden_p, r1_addr_i);
    end
  end

endmodule

// File: rtl/mem_2r1w_sync_read_port.sv
// One registered read port: range check, word select, hold when idle.
module mem_2r1w_sync_read_port
  import mem_2r1w_sync_pkg::*;
#(
  parameter int width_p      = 32,
  parameter int els_p        = 32,
  parameter int addr_width_p = safe_clog2(els_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    v_i,
  input  logic [addr_width_p-1:0] addr_i,
  input  logic [width_p-1:0]      mem_i [els_p],
  output logic [width_p-1:0]      data_o
);

  logic               in_range_s;
  logic [width_p-1:0] data_d;
  logic [width_p-1:0] data_q;

  // Next output word: selected entry, zero when out of range, old value when idle.
  always_comb begin
    in_range_s = addr_in_range(32'(addr_i), 32'(els_p));
    data_d     = data_q;
    if (v_i) begin
      if (in_range_s) begin
        data_d = mem_i[addr_i];
      end else begin
        data_d = '0;
      end
    end else begin
      data_d = data_q;
    end
  end

  // Output register, cleared asynchronously so the port reads zero during reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/mem_2r1w_sync.sv
// Register-file storage core: one write port, two independent registered read ports.
// Reads see the array contents from before the same edge's write (read-before-write).
module mem_2r1w_sync
  import mem_2r1w_sync_pkg::*;
#(
  parameter int width_p                = 32,
  parameter int els_p                  = 32,
  parameter int harden_p               = 0,
  parameter int read_write_same_addr_p = 0,
  localparam int addr_width_lp         = safe_clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic                     r0_v_i,
  input  logic [addr_width_lp-1:0] r0_addr_i,
  output logic [width_p-1:0]       r0_data_o,
  input  logic                     r1_v_i,
  input  logic [addr_width_lp-1:0] r1_addr_i,
  output logic [width_p-1:0]       r1_data_o
);

  // Storage is deliberately not reset; words are undefined until written.
  logic [width_p-1:0] mem_q [els_p];
  logic               w_en_s;

  // Writes are accepted only outside reset and only to existing words.
  always_comb begin
    w_en_s = 1'b0;
    if (reset_n_i && w_v_i && addr_in_range(32'(w_addr_i), 32'(els_p))) begin
      w_en_s = 1'b1;
    end else begin
      w_en_s = 1'b0;
    end
  end

  // Array update; read ports sample mem_q before this takes effect.
  always_ff @(posedge clk_i) begin
    if (w_en_s) begin
      mem_q[w_addr_i] <= w_data_i;
    end
  end

  mem_2r1w_sync_read_port #(
    .width_p     (width_p),
    .els_p       (els_p),
    .addr_width_p(addr_width_lp)
  ) u_r0 (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .v_i      (r0_v_i),
    .addr_i   (r0_addr_i),
    .mem_i    (mem_q),
    .data_o   (r0_data_o)
  );

  mem_2r1w_sync_read_port #(
    .width_p     (width_p),
    .els_p       (els_p),
    .addr_width_p(addr_width_lp)
  ) u_r1 (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .v_i      (r1_v_i),
    .addr_i   (r1_addr_i),
    .mem_i    (mem_q),
    .data_o   (r1_data_o)
  );

  // Collision monitoring only matters when the surrounding logic promises to avoid it.
  if (read_write_same_addr_p == 0) begin : g_collision_chk
    mem_2r1w_sync_checker #(
      .addr_width_p(addr_width_lp),
      .harden_p    (harden_p)
    ) u_chk (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .w_v_i    (w_v_i),
      .w_addr_i (w_addr_i),
      .r0_v_i   (r0_v_i),
      .r0_addr_i(r0_addr_i),
      .r1_v_i   (r1_v_i),
      .r1_addr_i(r1_addr_i)
    );
  end

endmodule

// File: tb/tb_mem_2r1w_sync.sv
// Directed scoreboard bench: a 32-word instance for the main behaviours and
// a 6-word instance for out-of-range addressing.
module tb_mem_2r1w_sync;

  logic clk = 1'b0;
  logic rst_n;

  // Instance A: 32 words.
  logic        w_v;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic        r0_v;
  logic [4:0]  r0_addr;
  logic [31:0] r0_data;
  logic        r1_v;
  logic [4:0]  r1_addr;
  logic [31:0] r1_data;

  // Instance B: 6 words (3-bit address, 6 and 7 are out of range).
  logic        b_w_v;
  logic [2:0]  b_w_addr;
  logic [31:0] b_w_data;
  logic        b_r0_v;
  logic [2:0]  b_r0_addr;
  logic [31:0] b_r0_data;
  logic        b_r1_v;
  logic [2:0]  b_r1_addr;
  logic [31:0] b_r1_data;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp0_q [$];
  logic [31:0] exp1_q [$];

  always #5 clk = ~clk;

  mem_2r1w_sync #(
    .width_p(32), .els_p(32), .harden_p(0), .read_write_same_addr_p(1)
  ) dut_a (
    .clk_i(clk), .reset_n_i(rst_n),
    .w_v_i(w_v), .w_addr_i(w_addr), .w_data_i(w_data),
    .r0_v_i(r0_v), .r0_addr_i(r0_addr), .r0_data_o(r0_data),
    .r1_v_i(r1_v), .r1_addr_i(r1_addr), .r1_data_o(r1_data)
  );

  mem_2r1w_sync #(
    .width_p(32), .els_p(6), .harden_p(1), .read_write_same_addr_p(1)
  ) dut_b (
    .clk_i(clk), .reset_n_i(rst_n),
    .w_v_i(b_w_v), .w_addr_i(b_w_addr), .w_data_i(b_w_data),
    .r0_v_i(b_r0_v), .r0_addr_i(b_r0_addr), .r0_data_o(b_r0_data),
    .r1_v_i(b_r1_v), .r1_addr_i(b_r1_addr), .r1_data_o(b_r1_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock on instance A; e0/e1 are the outputs expected after this edge.
  task automatic a_cycle(input string tag,
                         input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                         input logic v0, input logic [4:0] a0,
                         input logic v1, input logic [4:0] a1,
                         input logic [31:0] e0, input logic [31:0] e1);
    w_v = wv; w_addr = wa; w_data = wd;
    r0_v = v0; r0_addr = a0; r1_v = v1; r1_addr = a1;
    exp0_q.push_back(e0);
    exp1_q.push_back(e1);
    @(posedge clk); #1;
    check({tag, "/r0"}, r0_data, exp0_q.pop_front());
    check({tag, "/r1"}, r1_data, exp1_q.pop_front());
    w_v = 1'b0; r0_v = 1'b0; r1_v = 1'b0;
  endtask

  // One clock on instance B.
  task automatic b_cycle(input string tag,
                         input logic wv, input logic [2:0] wa, input logic [31:0] wd,
                         input logic v0, input logic [2:0] a0,
                         input logic v1, input logic [2:0] a1,
                         input logic [31:0] e0, input logic [31:0] e1);
    b_w_v = wv; b_w_addr = wa; b_w_data = wd;
    b_r0_v = v0; b_r0_addr = a0; b_r1_v = v1; b_r1_addr = a1;
    exp0_q.push_back(e0);
    exp1_q.push_back(e1);
    @(posedge clk); #1;
    check({tag, "/b_r0"}, b_r0_data, exp0_q.pop_front());
    check({tag, "/b_r1"}, b_r1_data, exp1_q.pop_front());
    b_w_v = 1'b0; b_r0_v = 1'b0; b_r1_v = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    w_v = 1'b0; w_addr = 5'd0; w_data = 32'd0;
    r0_v = 1'b0; r0_addr = 5'd0; r1_v = 1'b0; r1_addr = 5'd0;
    b_w_v = 1'b0; b_w_addr = 3'd0; b_w_data = 32'd0;
    b_r0_v = 1'b0; b_r0_addr = 3'd0; b_r1_v = 1'b0; b_r1_addr = 3'd0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset/r0", r0_data, 32'h0);
    check("reset/r1", r1_data, 32'h0);
    check("reset/b_r0", b_r0_data, 32'h0);
    check("reset/b_r1", b_r1_data, 32'h0);
    rst_n = 1'b1;

    // Prime r0 with a known nonzero value.
    a_cycle("wr1",  1'b1, 5'd1, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0);
    a_cycle("rd1",  1'b0, 5'd0, 32'h0,        1'b1, 5'd1, 1'b0, 5'd0, 32'hDEADBEEF, 32'h0);

    // Asynchronous clear mid-cycle, no clock edge in between.
    #2 rst_n = 1'b0;
    #1;
    check("async_rst/r0", r0_data, 32'h0);
    check("async_rst/r1", r1_data, 32'h0);
    // Write and read attempted while reset is held must be ignored.
    w_v = 1'b1; w_addr = 5'd1; w_data = 32'h12345678;
    r0_v = 1'b1; r0_addr = 5'd1;
    @(posedge clk); #1;
    check("rst_hold/r0", r0_data, 32'h0);
    w_v = 1'b0; r0_v = 1'b0;
    rst_n = 1'b1;
    a_cycle("rst_nowr", 1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b0, 5'd0, 32'hDEADBEEF, 32'h0);

    // Basic write then read, one-cycle latency.
    a_cycle("wr3",   1'b1, 5'd3, 32'h11111111, 1'b0, 5'd0, 1'b0, 5'd0, 32'hDEADBEEF, 32'h0);
    a_cycle("rd3",   1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 1'b0, 5'd0, 32'h11111111, 32'h0);
    // Hold while the last-read word is rewritten.
    a_cycle("hold1", 1'b1, 5'd3, 32'h22222222, 1'b0, 5'd3, 1'b0, 5'd0, 32'h11111111, 32'h0);
    a_cycle("hold2", 1'b0, 5'd0, 32'h0,        1'b0, 5'd3, 1'b0, 5'd0, 32'h11111111, 32'h0);
    a_cycle("rd3b",  1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 1'b0, 5'd0, 32'h22222222, 32'h0);

    // Dual independent reads.
    a_cycle("wr5",   1'b1, 5'd5, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0, 5'd0, 32'h22222222, 32'h0);
    a_cycle("wr6",   1'b1, 5'd6, 32'h5A5A5A5A, 1'b0, 5'd0, 1'b0, 5'd0, 32'h22222222, 32'h0);
    a_cycle("dual",  1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 1'b1, 5'd6, 32'hA5A5A5A5, 32'h5A5A5A5A);
    a_cycle("same5", 1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 1'b1, 5'd5, 32'hA5A5A5A5, 32'hA5A5A5A5);

    // Collisions: reads return pre-write contents, the write still lands.
    a_cycle("wr7",   1'b1, 5'd7, 32'h0000000F, 1'b0, 5'd0, 1'b0, 5'd0, 32'hA5A5A5A5, 32'hA5A5A5A5);
    a_cycle("col1",  1'b1, 5'd7, 32'h000000F0, 1'b0, 5'd0, 1'b1, 5'd7, 32'hA5A5A5A5, 32'h0000000F);
    a_cycle("after1",1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b1, 5'd7, 32'hA5A5A5A5, 32'h000000F0);
    a_cycle("col2",  1'b1, 5'd7, 32'h00000F00, 1'b1, 5'd7, 1'b1, 5'd7, 32'h000000F0, 32'h000000F0);
    a_cycle("after2",1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 1'b0, 5'd0, 32'h00000F00, 32'h000000F0);
    // Highest in-range address of the 32-word array.
    a_cycle("wr31",  1'b1, 5'd31, 32'hC0FFEE31, 1'b0, 5'd0, 1'b0, 5'd0, 32'h00000F00, 32'h000000F0);
    a_cycle("rd31",  1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 1'b1, 5'd31, 32'h00000F00, 32'hC0FFEE31);

    // Instance B: fill all six words, attempt writes past the end.
    for (int i = 0; i < 6; i++) begin
      b_cycle("b_fill", 1'b1, 3'(i), 32'h10 + 32'h01010101 * 32'(i),
              1'b0, 3'd0, 1'b0, 3'd0, 32'h0, 32'h0);
    end
    b_cycle("b_wr6", 1'b1, 3'd6, 32'hFFFFFFFF, 1'b0, 3'd0, 1'b0, 3'd0, 32'h0, 32'h0);
    b_cycle("b_wr7", 1'b1, 3'd7, 32'hFFFFFFFF, 1'b0, 3'd0, 1'b0, 3'd0, 32'h0, 32'h0);
    // Load nonzero first so an out-of-range read visibly returns zero.
    b_cycle("b_rd2", 1'b0, 3'd0, 32'h0, 1'b1, 3'd2, 1'b1, 3'd3, 32'h02020212, 32'h03030313);
    b_cycle("b_oor", 1'b0, 3'd0, 32'h0, 1'b1, 3'd6, 1'b1, 3'd7, 32'h0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      b_cycle("b_scan", 1'b0, 3'd0, 32'h0, 1'b1, 3'(i), 1'b1, 3'(5 - i),
              32'h10 + 32'h01010101 * 32'(i), 32'h10 + 32'h01010101 * 32'(5 - i));
    end

    check("queue_drained", 32'(exp0_q.size() + exp1_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_2r1w_sync.md
Name: mem_2r1w_sync

Overview:
Synchronous register-file memory with two independent read ports and one write port. Reads are registered: data appears the cycle after the read is requested. It is the storage core under the vanilla core's bypassing register-file wrapper. That wrapper suppresses reads that collide with a same-cycle write and supplies the forwarded data itself.

Parameters:
width_p, 32, bits per word (>=1)
els_p, 32, number of words (>=1; need not be a power of 2)
addr_width_lp, safe_clog2(els_p), address width; safe_clog2 returns 1 when els_p==1; derived, not overridden
harden_p, 0, request hard macro; no functional effect in this RTL, behaviour identical for 0/1
read_write_same_addr_p, 0, 1 = same-cycle read/write to one address is legal; 0 = it is a usage error

Ports:
clk_i  in  1  clock; all state updates on rising edge
reset_n_i  in  1  asynchronous active-low reset
w_v_i  in  1  write enable
w_addr_i  in  addr_width_lp  write address
w_data_i  in  width_p  write data
r0_v_i  in  1  port-0 read request
r0_addr_i  in  addr_width_lp  port-0 read address
r0_data_o  out  width_p  port-0 read data (registered)
r1_v_i  in  1  port-1 read request
r1_addr_i  in  addr_width_lp  port-1 read address
r1_data_o  out  width_p  port-1 read data (registered)

Behaviour:
- Reset (reset_n_i=0, asynchronous): r0_data_o and r1_data_o go to 0 immediately and stay 0 while reset is asserted.
- Reset does not clear the storage array. Contents are undefined (X in simulation) until written.
- Writes and reads are ignored while reset is asserted.
- Write: at a rising edge with w_v_i=1, mem[w_addr_i] <= w_data_i. w_addr_i >= els_p: write dropped.
- Read latency is 1 cycle. At a rising edge with rK_v_i=1, rK_data_o <= mem[rK_addr_i], using contents before that edge's write. rK_addr_i >= els_p: loads 0.
- rK_v_i=0: rK_data_o holds its previous value. A later write to the last-read address does not change the held output.
- Ports are fully independent. r0 and r1 may read the same or different addresses in the same cycle, each with or without a concurrent write.
- Same-cycle read and write to one address (w_v_i & rK_v_i & addresses equal): the read returns the OLD contents (read-before-write). The write still completes.
- When read_write_same_addr_p=0, that collision additionally triggers a simulation-only assertion error naming the port and address. Synthesized behaviour is unchanged.
- No handshake and no backpressure; every request is accepted every cycle.

Decomposition:
- Shared package: safe_clog2 function (returns 1 for inputs <=2).
- Optional sub-module mem_sync_read_port (one instance per read port): address decode, range check, registered output with async active-low clear and hold-on-invalid.
- Write logic and array stay in the top module.

Test Plan:
- Reset: hold reset_n_i=0 mid-operation after r0 has returned 0xDEADBEEF -> r0_data_o and r1_data_o become 0 without waiting for a clock edge.
- Basic write/read: write 0x11111111 to addr 3, next cycle r0 reads addr 3 -> r0_data_o = 0x11111111 one cycle after the request.
- Hold: same setup, then r0_v_i=0 while addr 3 is rewritten to 0x22222222 -> r0_data_o stays 0x11111111 until r0 reads again.
- Dual read: addr 5=0xA5A5A5A5, addr 6=0x5A5A5A5A; same cycle r0 reads 5 and r1 reads 6, then both read 5 -> 0xA5A5A5A5/0x5A5A5A5A, then 0xA5A5A5A5 on both.
- Collision: addr 7=0x0000000F, then in one cycle write 0x000000F0 to 7 while r1 reads 7 -> r1_data_o=0x0000000F; next read returns 0x000000F0. With read_write_same_addr_p=0 the assertion fires.
- Out of range with els_p=6: write 0xFFFFFFFF to addr 6, then r0 reads addr 6 -> r0_data_o=0; addr 0..5 unchanged.
